// File: rtl/alu_exec_seq.sv
// Multi-cycle integer execute unit: one-cycle logic/arith/compare, iterative shifts.
// Optional ALU_SHIFT4_EN: shift up to 4 bit positions per SHIFT cycle.
module alu_exec_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_sel,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SW = $clog2(XLEN);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SLT  = 4'b1101;
   localparam logic [3:0] OP_SLTU = 4'b1111;

   logic [1:0]      state;
   logic [XLEN-1:0] work;
   logic [SW-1:0]   cnt;
   logic [3:0]      op;

   logic [SW-1:0]   shamt;
   logic [SW-1:0]   step;
   logic [XLEN-1:0] comb_res;
   logic [XLEN-1:0] shf_res;
   logic            comb_ill;
   logic            is_shift;
   logic            accept;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;
   assign shamt    = b[SW-1:0];
   assign is_shift = (alu_sel == OP_SRL) |
                     (alu_sel == OP_SRA) |
                     (alu_sel == OP_SLL);

   always_comb begin
      comb_res = '0;
      comb_ill = 1'b0;
      case (alu_sel)
         OP_AND:  comb_res = a & b;
         OP_OR:   comb_res = a | b;
         OP_ADD:  comb_res = a + b;
         OP_XOR:  comb_res = a ^ b;
         OP_SUB:  comb_res = a - b;
         OP_SLT:  comb_res = {{(XLEN-1){1'b0}},
                              ($signed(a) < $signed(b))};
         OP_SLTU: comb_res = {{(XLEN-1){1'b0}}, (a < b)};
         // zero-amount shifts bypass the iterative path
         OP_SRL,
         OP_SRA,
         OP_SLL:  comb_res = a;
         default: comb_ill = 1'b1;
      endcase
   end

`ifdef ALU_SHIFT4_EN
   assign step = (cnt >= SW'(4)) ? SW'(4) : cnt;
`else
   assign step = SW'(1);
`endif

   // work[XLEN-1] always equals captured a[XLEN-1] for SRA
   always_comb begin
      shf_res = work >> step;
      case (op)
         OP_SLL:  shf_res = work << step;
         OP_SRA:  shf_res = $signed(work) >>> step;
         default: shf_res = work >> step;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         work      <= '0;
         cnt       <= '0;
         op        <= '0;
         result    <= '0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op <= alu_sel;
                  if (is_shift && (shamt != '0)) begin
                     work  <= a;
                     cnt   <= shamt;
                     state <= SHIFT;
                  end else begin
                     result    <= comb_res;
                     zero      <= (comb_res == '0);
                     illegal   <= comb_ill;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            SHIFT: begin
               work <= shf_res;
               cnt  <= cnt - step;
               if (cnt == step) begin
                  result    <= shf_res;
                  zero      <= (shf_res == '0);
                  illegal   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
